updi_echo_filter: RTL
=====================

# updi_echo_filter

Sits between the UPDI host logic and `uart_fifo`. UPDI is a single-wire half-duplex link, so every byte transmitted returns on the receive path as an echo. This block passes host bytes into the UART TX FIFO and records each one in an internal echo queue. It then drains the UART RX FIFO, checking and discarding echoes and forwarding only true target-response bytes downstream. It flags echo mismatches and missing echoes (timeout).

## Interface
- `DATA_BITS`, 8, byte width; must match `uart_fifo`.
- `ECHO_DEPTH`, 16, maximum outstanding un-echoed bytes; power of two, ≥2.
- `TIMEOUT_CYCLES`, 4096, cycles allowed without an echo while echoes are pending; ≥2.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst`=0 resets).
- `flush`  in  1  synchronous clear of echo queue, timeout counter and response register.
- `tx_byte`  in  DATA_BITS  host byte to transmit.
- `tx_valid`  in  1  host offers `tx_byte`.
- `tx_ready`  out  1  byte accepted this cycle when `tx_valid`&&`tx_ready`.
- `fifo_tx_data`  out  DATA_BITS  to `uart_fifo.tx_data`; equals `tx_byte`.
- `fifo_tx_wr_en`  out  1  to `uart_fifo.tx_fifo_wr_en`.
- `fifo_tx_full`  in  1  from `uart_fifo.tx_fifo_full`.
- `fifo_rx_data`  in  DATA_BITS  from `uart_fifo.rx_data`; head of RX FIFO, valid while `fifo_rx_empty`=0.
- `fifo_rx_empty`  in  1  from `uart_fifo.rx_fifo_empty`.
- `fifo_rx_rd_en`  out  1  to `uart_fifo.rx_fifo_rd_en`; pops head at the edge.
- `rsp_data`  out  DATA_BITS  forwarded response byte.
- `rsp_valid`  out  1  `rsp_data` valid.
- `rsp_ready`  in  1  consumer takes `rsp_data` when `rsp_valid`&&`rsp_ready`.
- `echo_pending`  out  $clog2(ECHO_DEPTH+1)  bytes sent but not yet echoed.
- `err_mismatch`  out  1  one-cycle pulse: echo differed from the sent byte.
- `err_timeout`  out  1  one-cycle pulse: echo timeout; queue cleared.

## Operation
- TX path, combinational:
  - `tx_ready` = rst && !flush && !fifo_tx_full && (echo_pending < ECHO_DEPTH).
  - `fifo_tx_wr_en` = tx_valid && tx_ready.
  - Accepted byte is written into echo queue (circular, ECHO_DEPTH entries) on the same edge.
- RX classification uses `echo_pending` before this cycle's push. A byte accepted in the same cycle can never be the echo of the current RX head.
  - **ECHO** (pending>0, !fifo_rx_empty): `fifo_rx_rd_en`=1; pop RX and echo queue together. If the values differ, pulse `err_mismatch` next cycle. Echo is never forwarded.
  - **RESPONSE** (pending=0, !fifo_rx_empty): `fifo_rx_rd_en` = !rsp_valid || rsp_ready. On pop, register the byte into `rsp_data` and set `rsp_valid`.
  - `rsp_valid` clears on handshake without a new pop.
- Simultaneous TX push and echo pop: `echo_pending` unchanged; queue pointers wrap mod ECHO_DEPTH.
- Timeout counter:
  - Counter width $clog2(TIMEOUT_CYCLES+1).
  - Cleared when pending=0 or on any echo pop; otherwise increments.
  - On reaching TIMEOUT_CYCLES: pulse `err_timeout`, empty echo queue, clear counter.
  - A same-cycle TX push is dropped from the queue; its byte still goes to the UART.
- `flush` priority over all: queue emptied, counter 0, `rsp_valid` 0, `tx_ready`=0, `fifo_rx_rd_en`=0 that cycle.
- Reset (`rst`=0, asynchronous):
  - Outputs: `rsp_valid`=0, `rsp_data`=0, `echo_pending`=0, `err_mismatch`=0, `err_timeout`=0; pointers and counter 0.
  - `tx_ready`, `fifo_tx_wr_en` and `fifo_rx_rd_en` forced 0 while in reset.

## Timing
- `fifo_tx_wr_en`, `tx_ready`, `fifo_rx_rd_en` are combinational, zero latency.
- RX head present at cycle N with RESPONSE class and response register free: `rsp_valid`=1 at N+1.
- Mismatch: `err_mismatch` high exactly cycle N+1 after the popping edge.
- Back-to-back pops: one RX byte per cycle sustained when `rsp_ready`=1.
- Timeout: `err_timeout` rises TIMEOUT_CYCLES cycles after the last echo pop or first push into an empty queue.

## Test plan
- Loopback through `uart_fifo` (`rx`=`tx`, UART_CLK_DIV=10): send 0x55, 0xAA, 0x01 -> `echo_pending` rises to 3 and returns to 0; `rsp_valid` never asserts; no errors.
- Response forwarding: pending=0, model RX FIFO holds 0x42, 0x43, `rsp_ready`=0 -> `rsp_valid`=1 with 0x42 one cycle later and held; `fifo_rx_rd_en`=0. Raise `rsp_ready` -> 0x43 follows next cycle.
- Mismatch: send 0x10, model returns 0x11 -> single-cycle `err_mismatch`; `echo_pending` 1→0; nothing forwarded.
- Timeout (TIMEOUT_CYCLES=50): send 0x20 with RX silent -> `err_timeout` pulses 50 cycles after the push edge; `echo_pending`→0. A later RX byte 0x33 is forwarded as a response.
- Full queue (ECHO_DEPTH=4): RX stalled, offer 5 bytes -> 4 accepted; `tx_ready`=0 on the fifth, no `fifo_tx_wr_en`. Also `fifo_tx_full`=1 -> `tx_ready`=0.
- Reset mid-operation: pending=3, `rsp_valid`=1, drive `rst`=0 asynchronously -> all outputs cleared before the next edge. After release, RX byte 0x7E is forwarded as a response.

Source files
------------

// File: rtl/updi_echo_filter.sv
// updi_echo_filter: forwards host bytes to the UART, strips their echoes from the RX stream
// and forwards only target responses, flagging echo mismatches and missing echoes.
module updi_echo_filter #(
    parameter int DATA_BITS      = 8,
    parameter int ECHO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [DATA_BITS-1:0]                  tx_byte,
    input  logic                                  tx_valid,
    output logic                                  tx_ready,
    output logic [DATA_BITS-1:0]                  fifo_tx_data,
    output logic                                  fifo_tx_wr_en,
    input  logic                                  fifo_tx_full,
    input  logic [DATA_BITS-1:0]                  fifo_rx_data,
    input  logic                                  fifo_rx_empty,
    output logic                                  fifo_rx_rd_en,
    output logic [DATA_BITS-1:0]                  rsp_data,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [$clog2(ECHO_DEPTH+1)-1:0]       echo_pending,
    output logic                                  err_mismatch,
    output logic                                  err_timeout
);
    localparam int PW = $clog2(ECHO_DEPTH);
    localparam int CW = $clog2(ECHO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH  = CW'(ECHO_DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [DATA_BITS-1:0] echo_q [ECHO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [TW-1:0]        t_cnt;
    logic                 pending_any, echo_pop, rsp_pop, timeout_hit;

    // RX head is an echo whenever anything is outstanding; a same-cycle push never counts
    always_comb begin
        pending_any   = echo_pending != '0;
        tx_ready      = rst && !flush && !fifo_tx_full && (echo_pending < DEPTH);
        fifo_tx_wr_en = tx_valid && tx_ready;
        fifo_tx_data  = tx_byte;
        fifo_rx_rd_en = rst && !flush && !fifo_rx_empty && (pending_any || !rsp_valid || rsp_ready);
        echo_pop      = fifo_rx_rd_en && pending_any;
        rsp_pop       = fifo_rx_rd_en && !pending_any;
        timeout_hit   = pending_any && !echo_pop && t_cnt == T_LAST;
    end

    always_ff @(posedge clk)
        if (fifo_tx_wr_en && !timeout_hit) echo_q[wr_ptr] <= tx_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            echo_pending <= '0;
            t_cnt        <= '0;
            rsp_data     <= '0;
            rsp_valid    <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            echo_pending <= '0;
            t_cnt        <= '0;
            rsp_valid    <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_mismatch <= echo_pop && (fifo_rx_data != echo_q[rd_ptr]);
            err_timeout  <= timeout_hit;
            if (timeout_hit) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                echo_pending <= '0;
                t_cnt        <= '0;
            end else begin
                wr_ptr       <= wr_ptr + PW'(fifo_tx_wr_en);
                rd_ptr       <= rd_ptr + PW'(echo_pop);
                echo_pending <= echo_pending + CW'(fifo_tx_wr_en) - CW'(echo_pop);
                t_cnt        <= (!pending_any || echo_pop) ? '0 : t_cnt + TW'(1);
            end
            if (rsp_pop) begin
                rsp_data  <= fifo_rx_data;
                rsp_valid <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule
